soc_dp_ram: RTL and testbench

Parametrised true dual-port SoC RAM, successor to the single-port scratch RAM. Port A is a read-only instruction fetch port; port B is a read/write data port with byte enables. Both ports share one array, have a configurable read latency (1 or 2 cycles) and a registered ack aligned with data validity. Port B flags accesses that fall outside its address window. Optional .hex init for simulation.

---
 rtl/soc_ram_pkg.sv | 25 ++
 rtl/soc_ram_rd_pipe.sv | 79 +++++++
 rtl/soc_dp_ram.sv | 116 +++++++++++
 tb/tb_soc_dp_ram.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ram_pkg.sv
// Shared definitions for the SoC dual-port RAM: collision policy codes and
// the byte-enable merge helper used by the write path and WRITE_FIRST bypass.
package soc_ram_pkg;

    localparam int unsigned RW_READ_FIRST  = 0;
    localparam int unsigned RW_WRITE_FIRST = 1;

    localparam int unsigned MAX_DATA_W = 128;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(MAX_BE_W); k++) begin
            if (be[k]) res[k*8 +: 8] = new_word[k*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_ram_rd_pipe.sv
// Read-response pipeline for one RAM port: registers array data, ack and err
// with 1 or 2 cycles of latency. Data only updates when a read completes.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_vld           : request accepted this cycle (produces one ack)
//   i_upd           : request returns data (read), qualifies i_data
//   i_err           : request is an error response
//   i_data          : array read word
//   o_data/o_ack/o_err : registered response
module soc_ram_rd_pipe #(
    parameter int unsigned p_latency = 1,
    parameter int unsigned p_width   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vld,
    input  logic               i_upd,
    input  logic               i_err,
    input  logic [p_width-1:0] i_data,
    output logic [p_width-1:0] o_data,
    output logic               o_ack,
    output logic               o_err
);

    logic               ack_d, err_d, upd_d;
    logic [p_width-1:0] data_d;
    logic               ack_q, err_q;
    logic [p_width-1:0] data_q;

    if (p_latency == 2) begin : g_lat2
        logic               s1_vld_q, s1_err_q, s1_upd_q;
        logic [p_width-1:0] s1_data_q;

        // Array output register; valids are cleared by reset so in-flight
        // responses are killed.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s1_vld_q <= 1'b0;
                s1_err_q <= 1'b0;
                s1_upd_q <= 1'b0;
            end else begin
                s1_vld_q <= i_vld;
                s1_err_q <= i_vld & i_err;
                s1_upd_q <= i_vld & i_upd;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_vld && i_upd) s1_data_q <= i_data;
        end

        assign ack_d  = s1_vld_q;
        assign err_d  = s1_err_q;
        assign upd_d  = s1_upd_q;
        assign data_d = s1_data_q;
    end else begin : g_lat1
        assign ack_d  = i_vld;
        assign err_d  = i_vld & i_err;
        assign upd_d  = i_vld & i_upd;
        assign data_d = i_data;
    end

    // Output register: ack/err pulse, data holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            if (upd_d) data_q <= data_d;
        end
    end

    assign o_data = data_q;
    assign o_ack  = ack_q;
    assign o_err  = err_q;

endmodule

// File: rtl/soc_dp_ram.sv
// True dual-port SoC RAM. Port A: read-only fetch port, no window check.
// Port B: read/write data port with byte enables and window-miss error.
//   i_clk, i_rst                        : clock, synchronous active-high reset
//   i_a_addr, i_a_rd_en                 : port A request
//   o_a_rd_data, o_a_ack                : port A response
//   i_b_addr, i_b_be, i_b_wr_en,
//   i_b_wr_data, i_b_rd_en              : port B request (write wins over read)
//   o_b_rd_data, o_b_ack, o_b_err       : port B response
//   o_busy                              : always 0
module soc_dp_ram
    import soc_ram_pkg::*;
#(
    parameter logic [31:0] p_addr_base  = 32'h1000_0000,
    parameter logic [31:0] p_addr_mask  = 32'hffff_f000,
    parameter int unsigned p_data_width = 32,
    parameter int unsigned p_depth_pw2  = 13,
    parameter int unsigned p_rd_latency = 1,
    parameter int unsigned p_rw_mode    = RW_READ_FIRST,
    parameter int unsigned p_init_mem   = 0,
    parameter string       p_init_file  = "init_file.hex"
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [31:0]               i_a_addr,
    input  logic                      i_a_rd_en,
    output logic [p_data_width-1:0]   o_a_rd_data,
    output logic                      o_a_ack,
    input  logic [31:0]               i_b_addr,
    input  logic [p_data_width/8-1:0] i_b_be,
    input  logic                      i_b_wr_en,
    input  logic [p_data_width-1:0]   i_b_wr_data,
    input  logic                      i_b_rd_en,
    output logic [p_data_width-1:0]   o_b_rd_data,
    output logic                      o_b_ack,
    output logic                      o_b_err,
    output logic                      o_busy
);

    localparam int unsigned BYTES = p_data_width / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned DEPTH = 2 ** p_depth_pw2;

    if (p_rd_latency != 1 && p_rd_latency != 2) begin : g_bad_latency
        $error("soc_dp_ram: p_rd_latency must be 1 or 2");
    end
    if (p_data_width % 8 != 0 || p_data_width < 8 || p_data_width > MAX_DATA_W) begin : g_bad_width
        $error("soc_dp_ram: p_data_width must be a multiple of 8 in 8..128");
    end

    logic [p_data_width-1:0] mem_q [DEPTH];

    logic [p_depth_pw2-1:0]  a_idx, b_idx;
    logic                    b_hit, b_wr, b_rd, b_wr_hit, b_vld, a_vld;
    logic [p_data_width-1:0] wr_merged, a_rd_word, b_rd_word;
    logic                    a_err_unused;

    assign a_idx = p_depth_pw2'((i_a_addr & ~p_addr_mask) >> OFF_W);
    assign b_idx = p_depth_pw2'((i_b_addr & ~p_addr_mask) >> OFF_W);

    // Request qualification, byte merge and collision bypass.
    always_comb begin
        b_hit     = (i_b_addr & p_addr_mask) == p_addr_base;
        b_wr      = ~i_rst & i_b_wr_en;
        b_rd      = ~i_rst & i_b_rd_en & ~i_b_wr_en;
        b_wr_hit  = b_wr & b_hit;
        b_vld     = b_wr | b_rd;
        a_vld     = ~i_rst & i_a_rd_en;
        wr_merged = p_data_width'(be_merge(MAX_DATA_W'(mem_q[b_idx]),
                                           MAX_DATA_W'(i_b_wr_data),
                                           MAX_BE_W'(i_b_be)));
        a_rd_word = mem_q[a_idx];
        // WRITE_FIRST forwards the merged word when both ports hit one entry.
        if (p_rw_mode == RW_WRITE_FIRST && b_wr_hit && (b_idx == a_idx)) begin
            a_rd_word = wr_merged;
        end
        b_rd_word = b_hit ? mem_q[b_idx] : '0;
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (b_wr_hit) mem_q[b_idx] <= wr_merged;
    end

    soc_ram_rd_pipe #(
        .p_latency (p_rd_latency),
        .p_width   (p_data_width)
    ) u_a_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (a_vld),
        .i_upd  (a_vld),
        .i_err  (1'b0),
        .i_data (a_rd_word),
        .o_data (o_a_rd_data),
        .o_ack  (o_a_ack),
        .o_err  (a_err_unused)
    );

    soc_ram_rd_pipe #(
        .p_latency (p_rd_latency),
        .p_width   (p_data_width)
    ) u_b_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (b_vld),
        .i_upd  (b_rd),
        .i_err  (~b_hit),
        .i_data (b_rd_word),
        .o_data (o_b_rd_data),
        .o_ack  (o_b_ack),
        .o_err  (o_b_err)
    );

    assign o_busy = 1'b0;

endmodule

// File: tb/tb_soc_dp_ram.sv
// Bench for soc_dp_ram: three instances (lat1 READ_FIRST, lat1 WRITE_FIRST,
// lat2 READ_FIRST) share one stimulus stream and are compared every cycle
// against a transaction-level model, plus directed scenario checks.
module tb_soc_dp_ram;

    localparam int N_DUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a_addr, b_addr, b_wdata;
    logic        a_rd, b_wr, b_rd;
    logic [3:0]  b_be;

    wire [N_DUT-1:0]       a_ack, b_ack, b_err, busy;
    wire [N_DUT-1:0][31:0] a_dat, b_dat;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        soc_dp_ram #(
            .p_rd_latency ((g == 2) ? 2 : 1),
            .p_rw_mode    ((g == 1) ? 1 : 0)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_a_addr    (a_addr),
            .i_a_rd_en   (a_rd),
            .o_a_rd_data (a_dat[g]),
            .o_a_ack     (a_ack[g]),
            .i_b_addr    (b_addr),
            .i_b_be      (b_be),
            .i_b_wr_en   (b_wr),
            .i_b_wr_data (b_wdata),
            .i_b_rd_en   (b_rd),
            .o_b_rd_data (b_dat[g]),
            .o_b_ack     (b_ack[g]),
            .o_b_err     (b_err[g]),
            .o_busy      (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ack;
        logic        err;
        logic        upd;
        logic [31:0] data;
    } resp_t;

    logic [31:0] mem_m [1024];
    resp_t       pend_a [N_DUT];
    resp_t       pend_b [N_DUT];
    logic        ea_ack [N_DUT];
    logic        eb_ack [N_DUT];
    logic        eb_err [N_DUT];
    logic [31:0] ea_dat [N_DUT];
    logic [31:0] eb_dat [N_DUT];

    function automatic int lat_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr & 32'h0000_0fff) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = be[k] ? n[k*8 +: 8] : o[k*8 +: 8];
        return r;
    endfunction

    task automatic model_edge();
        resp_t       ra, rb, oa, ob;
        logic        hit, coll;
        logic [31:0] old_a, wmerged;
        if (rst) begin
            for (int i = 0; i < N_DUT; i++) begin
                pend_a[i] = '0; pend_b[i] = '0;
                ea_ack[i] = 1'b0; eb_ack[i] = 1'b0; eb_err[i] = 1'b0;
                ea_dat[i] = '0;   eb_dat[i] = '0;
            end
            return;
        end
        hit     = (b_addr & 32'hffff_f000) == 32'h1000_0000;
        old_a   = mem_m[widx(a_addr)];
        wmerged = merge(mem_m[widx(b_addr)], b_wdata, b_be);
        coll    = b_wr && hit && (widx(b_addr) == widx(a_addr));
        if (b_wr)      rb = '{ack: 1'b1, err: !hit, upd: 1'b0, data: 32'h0};
        else if (b_rd) rb = '{ack: 1'b1, err: !hit, upd: 1'b1,
                              data: hit ? mem_m[widx(b_addr)] : 32'h0};
        else           rb = '0;
        if (b_wr && hit) mem_m[widx(b_addr)] = wmerged;
        for (int i = 0; i < N_DUT; i++) begin
            ra = '{ack: a_rd, err: 1'b0, upd: a_rd,
                   data: (i == 1 && coll) ? wmerged : old_a};
            if (lat_of(i) == 2) begin
                oa = pend_a[i]; pend_a[i] = ra;
                ob = pend_b[i]; pend_b[i] = rb;
            end else begin
                oa = ra; ob = rb;
            end
            ea_ack[i] = oa.ack;
            if (oa.upd) ea_dat[i] = oa.data;
            eb_ack[i] = ob.ack;
            eb_err[i] = ob.ack & ob.err;
            if (ob.upd) eb_dat[i] = ob.data;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("a_ack[%0d]", i),  32'(a_ack[i]), 32'(ea_ack[i]));
            check($sformatf("a_data[%0d]", i), a_dat[i],      ea_dat[i]);
            check($sformatf("b_ack[%0d]", i),  32'(b_ack[i]), 32'(eb_ack[i]));
            check($sformatf("b_err[%0d]", i),  32'(b_err[i]), 32'(eb_err[i]));
            check($sformatf("b_data[%0d]", i), b_dat[i],      eb_dat[i]);
            check($sformatf("busy[%0d]", i),   32'(busy[i]),  32'h0);
        end
    endtask

    // One clock: model and DUT both consume the current inputs at the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic ard, input logic [31:0] aa, input logic bwr, input logic brd,
                         input logic [31:0] ba, input logic [3:0] be, input logic [31:0] wd);
        a_rd = ard; a_addr = aa; b_wr = bwr; b_rd = brd; b_addr = ba; b_be = be; b_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h1000_0000, 1'b0, 1'b0, 32'h1000_0000, 4'h0, 32'h0);
    endtask

    logic [31:0] w0;
    logic [31:0] ack_seq;

    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            pend_a[i] = '0; pend_b[i] = '0;
        end
        rst = 1'b1;
        idle();
        cycle();
        cycle();
        rst = 1'b0;

        // Fill the words used by the bench.
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 32'h1000_0000, 1'b1, 1'b0, 32'h1000_0000 + 32'(w * 4), 4'hF, $urandom);
            cycle();
        end

        // Full write then fetch.
        drive(1'b0, 32'h1000_0000, 1'b1, 1'b0, 32'h1000_0008, 4'hF, 32'hDEAD_BEEF);
        cycle();
        drive(1'b1, 32'h1000_0008, 1'b0, 1'b0, 32'h1000_0000, 4'h0, 32'h0);
        cycle();
        check("t1_a_ack", 32'(a_ack[0]), 32'h1);
        check("t1_a_data", a_dat[0], 32'hDEAD_BEEF);

        // Partial byte-enable write.
        drive(1'b0, 32'h1000_0000, 1'b1, 1'b0, 32'h1000_0008, 4'b0101, 32'h1122_3344);
        cycle();
        drive(1'b0, 32'h1000_0000, 1'b0, 1'b1, 32'h1000_0008, 4'h0, 32'h0);
        cycle();
        check("t2_b_data_l1", b_dat[0], 32'hDE22_BE44);
        idle();
        cycle();
        check("t2_b_data_l2", b_dat[2], 32'hDE22_BE44);

        // Same-word collision.
        drive(1'b0, 32'h1000_0000, 1'b1, 1'b0, 32'h1000_000C, 4'hF, 32'hAAAA_AAAA);
        cycle();
        drive(1'b1, 32'h1000_000C, 1'b1, 1'b0, 32'h1000_000C, 4'hF, 32'h5555_5555);
        cycle();
        check("t3_read_first", a_dat[0], 32'hAAAA_AAAA);
        check("t3_write_first", a_dat[1], 32'h5555_5555);
        idle();
        cycle();
        check("t3_read_first_l2", a_dat[2], 32'hAAAA_AAAA);

        // Back-to-back reads on the 2-cycle instance.
        ack_seq = 32'b01110;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b0, 32'h1000_0000, 1'b0, 1'b1, 32'h1000_0000 + 32'(c * 4), 4'h0, 32'h0);
            else       idle();
            cycle();
            check($sformatf("t4_ack_c%0d", c), 32'(b_ack[2]), 32'(ack_seq[c]));
        end

        // Window miss leaves word 0 untouched.
        w0 = mem_m[0];
        drive(1'b0, 32'h1000_0000, 1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'hFFFF_FFFF);
        cycle();
        check("t5_miss_ack", 32'(b_ack[0]), 32'h1);
        check("t5_miss_err", 32'(b_err[0]), 32'h1);
        drive(1'b0, 32'h1000_0000, 1'b0, 1'b1, 32'h1000_0000, 4'h0, 32'h0);
        cycle();
        check("t5_word0", b_dat[0], w0);
        check("t5_hit_err", 32'(b_err[0]), 32'h0);

        // Reset in the middle of a fetch; write during reset is dropped.
        drive(1'b1, 32'h1000_0008, 1'b0, 1'b0, 32'h1000_0000, 4'h0, 32'h0);
        cycle();
        rst = 1'b1;
        drive(1'b0, 32'h1000_0000, 1'b1, 1'b0, 32'h1000_0008, 4'hF, 32'h0);
        cycle();
        check("t6_ack_l2", 32'(a_ack[2]), 32'h0);
        check("t6_data_l2", a_dat[2], 32'h0);
        check("t6_data_l1", a_dat[0], 32'h0);
        rst = 1'b0;
        idle();
        for (int c = 0; c < 3; c++) begin
            cycle();
            check($sformatf("t6_no_ack_c%0d", c), 32'(a_ack[2]), 32'h0);
        end
        drive(1'b1, 32'h1000_0008, 1'b0, 1'b0, 32'h1000_0000, 4'h0, 32'h0);
        cycle();
        check("t6_intact", a_dat[0], 32'hDE22_BE44);

        // Randomized traffic over words 0..15 with occasional misses/resets.
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] aa, ba;
            rst = ($urandom_range(0, 99) == 0);
            aa  = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            ba  = (($urandom_range(0, 7) == 0) ? 32'h2000_0000 : 32'h1000_0000)
                  | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            drive(1'($urandom), aa, 1'($urandom), 1'($urandom), ba, 4'($urandom), $urandom);
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
